// File: rtl/shuffle_xbar_pipe_pkg.sv
// Constants and types shared by the arbiter, the shuffle crossbar and the PE array.
// The select width is fixed at 3 bits, so the lane count is fixed at 8.
package shuffle_pkg;

    localparam int LANES    = 8;
    localparam int SELW     = 3;
    localparam int DEF_DW   = 16;
    localparam int DEF_CNTW = 16;

    typedef logic [SELW-1:0]   lane_sel_t;
    typedef logic [DEF_DW-1:0] coef_t;

    // True when two output lanes name the same source lane, i.e. the selects are not a permutation.
    function automatic logic sel_has_dup(input logic [LANES*SELW-1:0] sel);
        logic dup;
        dup = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            for (int k = j + 1; k < LANES; k++) begin
                if (sel[j*SELW +: SELW] == sel[k*SELW +: SELW]) begin
                    dup = 1'b1;
                end
            end
        end
        return dup;
    endfunction

endpackage

// File: rtl/shuffle_xbar_pipe_if.sv
// Valid/ready beat bus of the shuffle crossbar: input side from the arbiter,
// output side to the multiplier array.
interface shuffle_xbar_pipe_if #(
    parameter int DW = 16
);
    import shuffle_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*DW-1:0]    in_data;
    logic [LANES*SELW-1:0]  in_sel;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*DW-1:0]    out_data;
    logic                   out_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/shuffle_xbar_pipe_lane_mux.sv
// One output lane of the crossbar: picks one of the LANES input words by a 3-bit select.
module shuffle_lane_mux
    import shuffle_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [LANES*DW-1:0] din,
    input  lane_sel_t           sel,
    output logic [DW-1:0]       dout
);

    logic [DW-1:0] lane [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
        assign lane[gi] = din[gi*DW +: DW];
    end

    // Every 3-bit select value is a valid index, so there is no out-of-range case.
    always_comb begin
        dout = lane[sel];
    end

endmodule

// File: rtl/shuffle_xbar_pipe.sv
// Two-stage valid/ready shuffle: S1 captures a beat, S2 registers the crossbar result.
// Also flags non-permutation selects (sticky) and counts completed blocks.
module shuffle_xbar_pipe
    import shuffle_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CNTW = DEF_CNTW
) (
    input  logic                clk,
    input  logic                rst_n,
    shuffle_xbar_pipe_if.slave  bus,
    input  logic                clr_err,
    output logic                perm_err,
    output logic [CNTW-1:0]     blk_cnt
);

    logic                   s1_v_reg;
    logic [LANES*DW-1:0]    s1_data_reg;
    logic [LANES*SELW-1:0]  s1_sel_reg;
    logic                   s1_last_reg;

    logic                   s2_v_reg;
    logic [LANES*DW-1:0]    s2_data_reg;
    logic                   s2_last_reg;

    logic                   perm_err_reg;
    logic [CNTW-1:0]        blk_cnt_reg;

    logic [LANES*DW-1:0]    xbar_data;
    logic                   s2_free;
    logic                   s1_adv;
    logic                   in_xfer;
    logic                   out_xfer;

    // in_ready looks through to out_ready; there is no skid buffer.
    assign s2_free  = !s2_v_reg || bus.out_ready;
    assign s1_adv   = s1_v_reg && s2_free;
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = s2_v_reg && bus.out_ready;

    assign bus.in_ready  = !s1_v_reg || s2_free;
    assign bus.out_valid = s2_v_reg;
    assign bus.out_data  = s2_data_reg;
    assign bus.out_last  = s2_last_reg;
    assign perm_err      = perm_err_reg;
    assign blk_cnt       = blk_cnt_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_xbar
        shuffle_lane_mux #(.DW(DW)) u_lane_mux (
            .din  (s1_data_reg),
            .sel  (s1_sel_reg[gi*SELW +: SELW]),
            .dout (xbar_data[gi*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg    <= 1'b0;
            s1_data_reg <= '0;
            s1_sel_reg  <= '0;
            s1_last_reg <= 1'b0;
        end else if (in_xfer) begin
            s1_v_reg    <= 1'b1;
            s1_data_reg <= bus.in_data;
            s1_sel_reg  <= bus.in_sel;
            s1_last_reg <= bus.in_last;
        end else if (s1_adv) begin
            s1_v_reg    <= 1'b0;
        end
    end

    // S2 only moves when it is empty or being drained, so a stalled beat holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg    <= 1'b0;
            s2_data_reg <= '0;
            s2_last_reg <= 1'b0;
        end else if (s2_free) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_data_reg <= xbar_data;
                s2_last_reg <= s1_last_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_err_reg <= 1'b0;
        end else if (s1_adv && sel_has_dup(s1_sel_reg)) begin
            perm_err_reg <= 1'b1;
        end else if (clr_err) begin
            perm_err_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_reg <= '0;
        end else if (out_xfer && s2_last_reg) begin
            blk_cnt_reg <= blk_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_shuffle_xbar_pipe.sv
// Bench for shuffle_xbar_pipe: table-driven beats plus hand sequences for stall,
// duplicate selects, counter wrap and mid-stream reset; outputs checked by a scoreboard.
module tb_shuffle_xbar_pipe;
    import shuffle_pkg::*;

    localparam int DW   = 16;
    localparam int CNTW = 3;    // small counter so the wrap is reachable in a short run
    localparam int W    = LANES * DW;
    localparam int SW   = LANES * SELW;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] sel;
        logic          last;
        logic [W-1:0]  exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           acc;
        bit           lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_err = 1'b0;
    logic            perm_err;
    logic [CNTW-1:0] blk_cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;
    exp_t sb[$];
    exp_t mon_x;
    bit   held_v = 1'b0;
    logic [W-1:0] held_data;
    vec_t vecs[5];

    shuffle_xbar_pipe_if #(.DW(DW)) bus ();

    shuffle_xbar_pipe #(.DW(DW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_err  (clr_err),
        .perm_err (perm_err),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkc(input string nm, input logic [CNTW-1:0] act, input logic [CNTW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    function automatic logic [W-1:0] mk_rev_data(input int base);
        logic [W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*DW +: DW] = DW'(base + LANES - 1 - j);
        return r;
    endfunction

    function automatic logic [SW-1:0] mk_sel_ident();
        logic [SW-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*SELW +: SELW] = SELW'(j);
        return r;
    endfunction

    function automatic logic [SW-1:0] mk_sel_rev();
        logic [SW-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*SELW +: SELW] = SELW'(LANES - 1 - j);
        return r;
    endfunction

    // Selects {0,0,2,3,4,5,6,7}: lane 1 duplicates lane 0's source.
    function automatic logic [SW-1:0] mk_sel_dup();
        logic [SW-1:0] r;
        r = mk_sel_ident();
        r[SELW +: SELW] = '0;
        return r;
    endfunction

    function automatic logic [W-1:0] mk_dup_exp(input int base);
        logic [W-1:0] r;
        r = mk_data(base);
        r[DW +: DW] = DW'(base);
        return r;
    endfunction

    // Drives one beat and waits for its acceptance; the expectation is queued at acceptance.
    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic l,
                        input logic [W-1:0] e);
        int   n;
        exp_t x;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_last  = l;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want in_ready=1 within 100 cycles");
        end else begin
            x.data = e;
            x.last = l;
            x.acc  = cyc;
            x.lat  = lat_mode;
            sb.push_back(x);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending beats want 0", sb.size());
        end
        @(negedge clk);
    endtask

    // Output monitor: scoreboard order, latency, and hold-while-stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk1("stall_valid", bus.out_valid, 1'b1);
                chkd("stall_data", bus.out_data, held_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want no beat", bus.out_data);
                end else begin
                    mon_x = sb.pop_front();
                    chkd("out_data", bus.out_data, mon_x.data);
                    chk1("out_last", bus.out_last, mon_x.last);
                    if (mon_x.lat) begin
                        total++;
                        if (cyc - mon_x.acc != 2) begin
                            bad++;
                            $display("FAIL latency: got %0d want 2", cyc - mon_x.acc);
                        end
                    end
                end
            end
            held_v    = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{data: mk_data(16'h100), sel: mk_sel_ident(), last: 1'b0, exp: mk_data(16'h100)};
        for (int b = 0; b < 4; b++) begin
            vecs[b+1] = '{data: mk_data(16'h200 + 16*b), sel: mk_sel_rev(), last: 1'b0,
                          exp: mk_rev_data(16'h200 + 16*b)};
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_perm_err", perm_err, 1'b0);
        chkc("rst_blk_cnt", blk_cnt, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Identity then four back-to-back reversals, latency 2 and 1 beat/cycle
        lat_mode = 1'b1;
        for (int i = 0; i < 5; i++) send(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].exp);
        idle();
        drain();
        chk1("perm_ok", perm_err, 1'b0);
        lat_mode = 1'b0;

        // Backpressure: 5 stalled cycles mid-stream with a continuous supply
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    send(mk_data(16'h300 + 16*b), mk_sel_rev(), 1'b0, mk_rev_data(16'h300 + 16*b));
                end
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk1("stall_in_ready", bus.in_ready, 1'b0);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Duplicate selects: sticky flag, set wins over clear, clear works
        send(mk_data(16'h400), mk_sel_dup(), 1'b0, mk_dup_exp(16'h400));
        idle();
        drain();
        chk1("dup_set", perm_err, 1'b1);
        send(mk_data(16'h410), mk_sel_dup(), 1'b0, mk_dup_exp(16'h410));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk1("dup_set_wins", perm_err, 1'b1);
        drain();
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk1("dup_cleared", perm_err, 1'b0);

        // Block counter: 3 blocks of 4 beats, then single-beat blocks up to the wrap
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                send(mk_data(16'h500 + 16*b), mk_sel_ident(), (k == 3), mk_data(16'h500 + 16*b));
            end
        end
        idle();
        drain();
        chkc("blk_cnt_3", blk_cnt, 3'd3);
        for (int b = 0; b < 4; b++) send(mk_data(16'h600), mk_sel_rev(), 1'b1, mk_rev_data(16'h600));
        idle();
        drain();
        chkc("blk_cnt_7", blk_cnt, 3'd7);
        send(mk_data(16'h610), mk_sel_rev(), 1'b1, mk_rev_data(16'h610));
        idle();
        drain();
        chkc("blk_cnt_wrap", blk_cnt, 3'd0);

        // Reset with both stages full
        send(mk_data(16'h700), mk_sel_ident(), 1'b1, mk_data(16'h700));
        idle();
        drain();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(mk_data(16'h710), mk_sel_dup(), 1'b1, mk_dup_exp(16'h710));
        send(mk_data(16'h720), mk_sel_ident(), 1'b1, mk_data(16'h720));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk1("pre_rst_perm", perm_err, 1'b1);
        chkc("pre_rst_cnt", blk_cnt, 3'd1);
        chk1("pre_rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk1("mid_rst_perm_err", perm_err, 1'b0);
        chkc("mid_rst_blk_cnt", blk_cnt, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk1("post_rst_no_stale", bus.out_valid, 1'b0);
        lat_mode = 1'b1;
        send(mk_data(16'h800), mk_sel_rev(), 1'b0, mk_rev_data(16'h800));
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
